uart_hex_word_rx: RTL and testbench

UART_HEX_WORD_RX -- requirements
Module: uart_hex_word_rx

---
 rtl/uart_hex_word_rx.sv | 212 +++++++++++++++++++++
 tb/tb_uart_hex_word_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_word_rx.sv
// 8N1 UART receiver with 16x oversampling, feeding a hex-line assembler that
// turns exactly eight hex digits terminated by CR into a 32-bit word.
module uart_hex_word_rx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        frame_err,
  output logic        hex_err
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} byte_st_t;
  typedef enum logic {A_ASSEMBLE, A_DISCARD} asm_st_t;

  // Returns {is_hex, nibble} for an ASCII character.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [7:0] v;
    v = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      v = c - 8'h30;
      return {1'b1, v[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      v = c - 8'h37;
      return {1'b1, v[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      v = c - 8'h57;
      return {1'b1, v[3:0]};
    end
    return 5'b0_0000;
  endfunction

  logic             r_rx_meta, r_rx_sync;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick;
  byte_st_t         r_bst, w_bst_nxt;
  logic [3:0]       r_phase, w_phase_nxt;
  logic [2:0]       r_bit_cnt, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_byte_done, w_frame_bad;
  asm_st_t          r_ast, w_ast_nxt;
  logic [3:0]       r_nib, w_nib_nxt;
  logic [31:0]      r_acc, w_acc_nxt;
  logic             w_word_ld, w_herr;
  logic [4:0]       w_hex;

  // Synchronizer and free-running 16x tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      if (r_div_cnt == DIV_W'(DIV - 1)) begin
        r_div_cnt <= '0;
        r_tick    <= 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
        r_tick    <= 1'b0;
      end
    end
  end

  // Byte FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bst     <= S_IDLE;
      r_phase   <= 4'd0;
      r_bit_cnt <= 3'd0;
    end else begin
      r_bst     <= w_bst_nxt;
      r_phase   <= w_phase_nxt;
      r_bit_cnt <= w_bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  always_comb begin
    w_bst_nxt   = r_bst;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_byte_done = 1'b0;
    w_frame_bad = 1'b0;
    case (r_bst)
      S_IDLE: begin
        w_phase_nxt = 4'd0;
        w_bit_nxt   = 3'd0;
        if (!r_rx_sync) w_bst_nxt = S_START;
      end
      S_START: begin
        if (r_tick) begin
          if (r_phase == 4'd7) begin
            w_phase_nxt = 4'd0;
            w_bst_nxt   = r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            w_phase_nxt = r_phase + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (r_tick) begin
          if (r_phase == 4'd15) begin
            w_phase_nxt = 4'd0;
            w_shift_nxt = {r_rx_sync, r_shift[7:1]};
            w_bit_nxt   = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_bst_nxt = S_STOP;
          end else begin
            w_phase_nxt = r_phase + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (r_tick) begin
          if (r_phase == 4'd15) begin
            w_phase_nxt = 4'd0;
            w_bst_nxt   = S_IDLE;
            w_byte_done = r_rx_sync;
            w_frame_bad = !r_rx_sync;
          end else begin
            w_phase_nxt = r_phase + 4'd1;
          end
        end
      end
      default: w_bst_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= w_byte_done;
      frame_err  <= w_frame_bad;
      if (w_byte_done) byte_data <= r_shift;
    end
  end

  // Hex assembler: consumes the registered byte/frame-error pulses
  assign w_hex = hex_decode(byte_data);

  always_comb begin
    w_ast_nxt = r_ast;
    w_nib_nxt = r_nib;
    w_acc_nxt = r_acc;
    w_word_ld = 1'b0;
    w_herr    = 1'b0;
    if (frame_err) begin
      w_ast_nxt = A_DISCARD;
      w_nib_nxt = 4'd0;
      w_acc_nxt = 32'd0;
    end else if (byte_valid && byte_data != CH_LF) begin
      if (r_ast == A_ASSEMBLE) begin
        if (byte_data == CH_CR) begin
          w_nib_nxt = 4'd0;
          w_acc_nxt = 32'd0;
          if (r_nib == 4'd8) w_word_ld = 1'b1;
          else               w_herr    = 1'b1;
        end else if (w_hex[4] && r_nib < 4'd8) begin
          w_acc_nxt = {r_acc[27:0], w_hex[3:0]};
          w_nib_nxt = r_nib + 4'd1;
        end else begin
          w_herr    = 1'b1;
          w_ast_nxt = A_DISCARD;
          w_nib_nxt = 4'd0;
          w_acc_nxt = 32'd0;
        end
      end else if (byte_data == CH_CR) begin
        w_ast_nxt = A_ASSEMBLE;
        w_nib_nxt = 4'd0;
        w_acc_nxt = 32'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ast      <= A_ASSEMBLE;
      r_nib      <= 4'd0;
      r_acc      <= 32'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
      hex_err    <= 1'b0;
    end else begin
      r_ast      <= w_ast_nxt;
      r_nib      <= w_nib_nxt;
      r_acc      <= w_acc_nxt;
      word_valid <= w_word_ld;
      hex_err    <= w_herr;
      if (w_word_ld) word <= r_acc;
    end
  end

endmodule

// File: tb/tb_uart_hex_word_rx.sv
// Directed bench for uart_hex_word_rx: serial stimulus with a scoreboard of
// expected bytes, words and hex-error bytes checked as the DUT emits pulses.
module tb_uart_hex_word_rx;
  localparam int BAUD   = 115200;
  localparam int CLK_HZ = BAUD * 64;
  localparam int BITC   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [31:0] word;
  logic        word_valid;
  logic        frame_err;
  logic        hex_err;

  uart_hex_word_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .word(word), .word_valid(word_valid),
    .frame_err(frame_err), .hex_err(hex_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_words[$];
  logic [7:0]  exp_herr[$];
  int cnt_byte = 0, cnt_word = 0, cnt_herr = 0, cnt_ferr = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_bv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_bv = 1'b0;
    end else begin
      if (byte_valid) begin
        cnt_byte++;
        chk("byte_expected", 32'(exp_bytes.size() > 0), 32'd1);
        if (exp_bytes.size() > 0) begin
          last_good = exp_bytes.pop_front();
          chk("byte_data", {24'd0, byte_data}, {24'd0, last_good});
        end
      end
      if (frame_err) begin
        cnt_ferr++;
        chk("ferr_bv_excl", {31'd0, byte_valid}, 32'd0);
        chk("ferr_data_hold", {24'd0, byte_data}, {24'd0, last_good});
      end
      if (word_valid) begin
        cnt_word++;
        chk("wv_latency", {31'd0, prev_bv}, 32'd1);
        chk("wv_after_cr", {24'd0, byte_data}, 32'h0D);
        chk("wv_herr_excl", {31'd0, hex_err}, 32'd0);
        chk("word_expected", 32'(exp_words.size() > 0), 32'd1);
        if (exp_words.size() > 0) chk("word", word, exp_words.pop_front());
      end
      if (hex_err) begin
        cnt_herr++;
        chk("herr_expected", 32'(exp_herr.size() > 0), 32'd1);
        if (exp_herr.size() > 0) chk("herr_byte", {24'd0, byte_data}, {24'd0, exp_herr.pop_front()});
      end
      prev_bv = byte_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITC) @(negedge clk);
    end
    if (stop_ok) begin
      exp_bytes.push_back(b);
      rx = 1'b1;
      repeat (BITC) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (BITC / 2 + 8) @(negedge clk);
      rx = 1'b1;
      repeat (BITC) @(negedge clk);
    end
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_byte_data"}, {24'd0, byte_data}, 32'd0);
    chk({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    chk({tag, "_word"}, word, 32'd0);
    chk({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_hex_err"}, {31'd0, hex_err}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_byte, b_word, b_herr, b_ferr;
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2 * BITC) @(negedge clk);
    chk("idle_no_byte", 32'(cnt_byte), 32'd0);

    b_byte = cnt_byte; b_word = cnt_word; b_herr = cnt_herr; b_ferr = cnt_ferr;
    exp_words.push_back(32'hDEADBEEF);
    send_str("DEADBEEF\r\n");
    chk("t1_bytes", 32'(cnt_byte - b_byte), 32'd10);
    chk("t1_words", 32'(cnt_word - b_word), 32'd1);
    chk("t1_herr", 32'(cnt_herr - b_herr), 32'd0);
    chk("t1_ferr", 32'(cnt_ferr - b_ferr), 32'd0);
    chk("t1_word", word, 32'hDEADBEEF);

    b_word = cnt_word;
    exp_words.push_back(32'h0000ABCD);
    send_str("0000abcd\r");
    chk("t2_words", 32'(cnt_word - b_word), 32'd1);
    chk("t2_word", word, 32'h0000ABCD);

    b_byte = cnt_byte; b_word = cnt_word; b_herr = cnt_herr; b_ferr = cnt_ferr;
    send_byte(8'h41, 1'b0);
    chk("t3_ferr", 32'(cnt_ferr - b_ferr), 32'd1);
    chk("t3_no_byte", 32'(cnt_byte - b_byte), 32'd0);
    exp_words.push_back(32'h12345678);
    send_str("x\r12345678\r");
    chk("t3_herr", 32'(cnt_herr - b_herr), 32'd0);
    chk("t3_words", 32'(cnt_word - b_word), 32'd1);
    chk("t3_word", word, 32'h12345678);

    b_word = cnt_word; b_herr = cnt_herr;
    exp_herr.push_back(8'h0D);
    send_str("1234\r");
    chk("t4a_herr", 32'(cnt_herr - b_herr), 32'd1);
    chk("t4a_word_hold", word, 32'h12345678);
    b_herr = cnt_herr;
    exp_herr.push_back(8'h39);
    send_str("123456789\r");
    chk("t4b_herr", 32'(cnt_herr - b_herr), 32'd1);
    chk("t4b_herr_q", 32'(exp_herr.size()), 32'd0);
    chk("t4_no_word", 32'(cnt_word - b_word), 32'd0);
    chk("t4b_word_hold", word, 32'h12345678);

    b_byte = cnt_byte; b_ferr = cnt_ferr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    chk("t5_no_byte", 32'(cnt_byte - b_byte), 32'd0);
    chk("t5_no_ferr", 32'(cnt_ferr - b_ferr), 32'd0);

    send_str("CA");
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    rx = 1'b0; repeat (BITC) @(negedge clk);
    rx = 1'b1; repeat (BITC) @(negedge clk);
    rx = 1'b1; repeat (BITC / 2) @(negedge clk);
    #3 rst = 1'b1;
    #1 chk_outputs_zero("rst_async");
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk_outputs_zero("rst_held");
    rst = 1'b0;
    last_good = 8'h00;
    b_byte = cnt_byte; b_word = cnt_word; b_herr = cnt_herr; b_ferr = cnt_ferr;
    repeat (2 * BITC) @(negedge clk);
    chk("t6_no_spurious", 32'(cnt_byte - b_byte), 32'd0);
    exp_words.push_back(32'hCAFEF00D);
    send_str("CAFEF00D\r");
    chk("t6_bytes", 32'(cnt_byte - b_byte), 32'd9);
    chk("t6_words", 32'(cnt_word - b_word), 32'd1);
    chk("t6_herr", 32'(cnt_herr - b_herr), 32'd0);
    chk("t6_word", word, 32'hCAFEF00D);

    chk("end_byte_q", 32'(exp_bytes.size()), 32'd0);
    chk("end_word_q", 32'(exp_words.size()), 32'd0);
    chk("end_herr_q", 32'(exp_herr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
